// File: rtl/dmem_lsu.sv
// Load/store initiator for the single-port data_mem. Sub-word stores use read-modify-write.
// Optional macro MISALIGN_TRAP_EN: misaligned requests return rsp_err without a memory access.
module dmem_lsu #(
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q;
   logic                we_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [1:0]          off_q;
   logic [MEM_AW-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [31:0]         rsp_rdata_q;
   logic                accept;
   logic                wait_done;
   logic                req_word;
   logic                trap;
   logic [1:0]          size_norm;
   logic                unused_addr_hi;

   // Upper address bits fall outside data_mem and are deliberately ignored.
   assign unused_addr_hi = ^req_addr[31:MEM_AW];

   assign req_word  = req_size[1];
   assign size_norm = {req_size[1], req_size[0] & ~req_size[1]};
   assign accept    = req_valid && req_ready;
   assign wait_done = (cnt_q == CntW'(RD_LAT - 1));

`ifdef MISALIGN_TRAP_EN
   logic err_q;
   assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_word && (req_addr[1:0] != 2'b00));
   assign rsp_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= trap;
      end
   end
`else
   assign trap    = 1'b0;
   assign rsp_err = 1'b0;
`endif

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      logic [15:0] h;
      sh = w >> {off, 3'b000};
      h  = off[1] ? w[31:16] : w[15:0];
      unique case (sz)
         2'b00:   extract = {{24{sh[7] & ~uns}}, sh[7:0]};
         2'b01:   extract = {{16{h[15] & ~uns}}, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] sz, input logic [1:0] off);
      merge = w;
      unique case (sz)
         2'b00: merge[{off, 3'b000} +: 8] = d[7:0];
         2'b01: begin
            if (off[1]) merge[31:16] = d[15:0];
            else        merge[15:0]  = d[15:0];
         end
         default: merge = d;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (trap)                  state_d = StResp;
               else if (req_we && req_word) state_d = StWr;
               else                       state_d = StRd;
            end
         end
         StRd: begin
            mem_ren = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (wait_done) state_d = we_q ? StWr : StResp;
         end
         StWr: begin
            mem_wen = 1'b1;
            state_d = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q        <= req_we;
            size_q      <= size_norm;
            uns_q       <= req_unsigned;
            off_q       <= req_addr[1:0];
            mem_addr_q  <= {req_addr[MEM_AW-1:2], 2'b00};
            mem_wdata_q <= req_wdata;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
         end
         if (state_q == StWait) begin
            cnt_q <= cnt_q + CntW'(1);
            if (wait_done) begin
               if (we_q) mem_wdata_q <= merge(mem_rdata, mem_wdata_q, size_q, off_q);
               else      rsp_rdata_q <= extract(mem_rdata, size_q, off_q, uns_q);
            end
         end
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural data_mem, vector table, response scoreboard,
// plus response back-pressure and reset-during-RMW sequences.
module tb_dmem_lsu;

   localparam int unsigned MEM_AW = 10;
   localparam int unsigned RD_LAT = 1;

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] W_AFTER_MIS = 32'h55EF80EF;
`else
   localparam logic [31:0] W_AFTER_MIS = 32'h55EF7FFF;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]        req_size;
   logic [31:0]       req_addr, req_wdata;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [31:0]       rsp_rdata;
   logic              mem_ren, mem_wen;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   dmem_lsu #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // data_mem model, read latency 1
   logic [31:0] mem [0:(2**(MEM_AW-2))-1];
   int          ren_cnt = 0;
   int          wen_cnt = 0;
   int          both_cnt = 0;
   logic [31:0] last_wdata = '0;
   logic [MEM_AW-1:0] last_waddr = '0;

   always @(posedge clk) begin
      if (mem_wen) begin
         mem[mem_addr[MEM_AW-1:2]] <= mem_wdata;
         last_wdata <= mem_wdata;
         last_waddr <= mem_addr;
         wen_cnt    <= wen_cnt + 1;
      end
      if (mem_ren) begin
         mem_rdata <= mem[mem_addr[MEM_AW-1:2]];
         ren_cnt   <= ren_cnt + 1;
      end
      if (mem_ren && mem_wen) both_cnt <= both_cnt + 1;
   end

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_ren;
      int          exp_wen;
      logic [31:0] exp_mwdata;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   n_checks = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic [31:0] mwdata);
      vec_t v;
      logic trap;
`ifdef MISALIGN_TRAP_EN
      trap = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
      trap = 1'b0;
`endif
      v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_err = trap;
      v.exp_rdata = (we || trap) ? 32'h0 : rdata;
      v.exp_mwdata = mwdata;
      if (trap)               begin v.exp_lat = 1; v.exp_ren = 0; v.exp_wen = 0; end
      else if (we && size[1]) begin v.exp_lat = 2; v.exp_ren = 0; v.exp_wen = 1; end
      else if (we)            begin v.exp_lat = 4; v.exp_ren = 1; v.exp_wen = 1; end
      else                    begin v.exp_lat = 3; v.exp_ren = 1; v.exp_wen = 0; end
      return v;
   endfunction

   // Drives one request and checks its response; hold>0 stalls rsp_ready for that many cycles.
   task automatic run_txn(input vec_t v, input int hold);
      vec_t e;
      int   k;
      int   ren0, wen0;
      sb_q.push_back(v);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      rsp_ready = (hold == 0);
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      check({v.name, " req_ready"}, {31'b0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      ren0 = ren_cnt;
      wen0 = wen_cnt;
      k = 1;
      while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
      e = sb_q.pop_front();
      if (!rsp_valid) begin
         n_checks++; n_err++;
         $display("FAIL %s timeout: no rsp_valid after %0d cycles", e.name, k);
         rsp_ready = 1'b1;
         return;
      end
      check({e.name, " latency"}, 32'(k), 32'(e.exp_lat));
      check({e.name, " rdata"}, rsp_rdata, e.exp_rdata);
      check({e.name, " err"}, {31'b0, rsp_err}, {31'b0, e.exp_err});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({e.name, " held valid"}, {31'b0, rsp_valid}, 32'h1);
         check({e.name, " held rdata"}, rsp_rdata, e.exp_rdata);
         check({e.name, " held req_ready"}, {31'b0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check({e.name, " idle after rsp"}, {31'b0, req_ready, rsp_valid}, 32'h2);
      check({e.name, " ren count"}, 32'(ren_cnt - ren0), 32'(e.exp_ren));
      check({e.name, " wen count"}, 32'(wen_cnt - wen0), 32'(e.exp_wen));
      if (e.exp_wen != 0) begin
         check({e.name, " mem_wdata"}, last_wdata, e.exp_mwdata);
         check({e.name, " mem_addr"}, 32'(last_waddr), {22'b0, e.addr[MEM_AW-1:2], 2'b00});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wen0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready/valid/err", {29'b0, req_ready, rsp_valid, rsp_err}, 32'h4);
      check("reset ren/wen", {30'b0, mem_ren, mem_wen}, 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset mem_addr", 32'(mem_addr), 32'h0);
      check("reset mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      //            name       we  size   uns addr          wdata         rdata         mem_wdata
      vecs.push_back(mk("sw4",   1, 2'b10, 0, 32'h4,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF));
      vecs.push_back(mk("lw4",   0, 2'b10, 0, 32'h4,        32'h0,        32'hDEADBEEF, 32'h0));
      vecs.push_back(mk("sb5",   1, 2'b00, 0, 32'h5,        32'h00000080, 32'h0,        32'hDEAD80EF));
      vecs.push_back(mk("lb5",   0, 2'b00, 0, 32'h5,        32'h0,        32'hFFFFFF80, 32'h0));
      vecs.push_back(mk("lbu5",  0, 2'b00, 1, 32'h5,        32'h0,        32'h00000080, 32'h0));
      vecs.push_back(mk("sh6a",  1, 2'b01, 0, 32'h6,        32'h00001234, 32'h0,        32'h123480EF));
      vecs.push_back(mk("lh6a",  0, 2'b01, 0, 32'h6,        32'h0,        32'h00001234, 32'h0));
      vecs.push_back(mk("sh6b",  1, 2'b01, 0, 32'h6,        32'hFFFFBEEF, 32'h0,        32'hBEEF80EF));
      vecs.push_back(mk("lh6b",  0, 2'b01, 0, 32'h6,        32'h0,        32'hFFFFBEEF, 32'h0));
      vecs.push_back(mk("lhu6",  0, 2'b01, 1, 32'h6,        32'h0,        32'h0000BEEF, 32'h0));
      vecs.push_back(mk("lw6",   0, 2'b10, 0, 32'h6,        32'h0,        32'hBEEF80EF, 32'h0));
      vecs.push_back(mk("lb7",   0, 2'b00, 0, 32'h7,        32'h0,        32'hFFFFFFBE, 32'h0));
      vecs.push_back(mk("lbu4",  0, 2'b00, 1, 32'h4,        32'h0,        32'h000000EF, 32'h0));
      vecs.push_back(mk("sb7",   1, 2'b00, 0, 32'h7,        32'hAAAAAA55, 32'h0,        32'h55EF80EF));
      vecs.push_back(mk("lw4b",  0, 2'b10, 0, 32'h4,        32'h0,        32'h55EF80EF, 32'h0));
      vecs.push_back(mk("sh5",   1, 2'b01, 0, 32'h5,        32'h00007FFF, 32'h0,        32'h55EF7FFF));
      vecs.push_back(mk("lw4c",  0, 2'b10, 0, 32'h4,        32'h0,        W_AFTER_MIS,  32'h0));
      vecs.push_back(mk("sz3st", 1, 2'b11, 0, 32'h8,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D));
      vecs.push_back(mk("sz3ld", 0, 2'b11, 0, 32'h8,        32'h0,        32'hCAFEF00D, 32'h0));
      vecs.push_back(mk("lwhi",  0, 2'b10, 0, 32'h10000008, 32'h0,        32'hCAFEF00D, 32'h0));
      vecs.push_back(mk("lh10",  0, 2'b01, 0, 32'hA,        32'h0,        32'hFFFFCAFE, 32'h0));
      vecs.push_back(mk("lhu8",  0, 2'b01, 1, 32'h8,        32'h0,        32'h0000F00D, 32'h0));

      foreach (vecs[i]) run_txn(vecs[i], 0);

      // Response back-pressure: three stalled cycles on a word load
      run_txn(mk("hold_lw", 0, 2'b10, 0, 32'h4, 32'h0, W_AFTER_MIS, 32'h0), 3);

      // Reset while a byte store waits for its read data
      wen0 = wen_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h5; req_wdata = 32'h11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rmw rd ren", {31'b0, mem_ren}, 32'h1);
      @(negedge clk);
      check("rmw wait wen", {31'b0, mem_wen}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("post-rst ready/valid", {30'b0, req_ready, rsp_valid}, 32'h2);
      check("post-rst wen", {31'b0, mem_wen}, 32'h0);
      check("post-rst mem_addr", 32'(mem_addr), 32'h0);
      check("post-rst mem_wdata", mem_wdata, 32'h0);
      repeat (3) @(negedge clk);
      check("post-rst no write", 32'(wen_cnt - wen0), 32'h0);
      run_txn(mk("lw_after_rst", 0, 2'b10, 0, 32'h4, 32'h0, W_AFTER_MIS, 32'h0), 0);

      check("ren and wen overlap", 32'(both_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
